// File: rtl/barrel_shift_pipe.sv
// Bidirectional logarithmic barrel shifter with selectable fill bit and per-level
// pipeline registers (PIPE_MASK). Optional sticky output under macro BSP_STICKY_EN.
module barrel_shift_pipe #(
  parameter int             SWR       = 26,
  parameter int             EWR       = 5,
  parameter logic [EWR-1:0] PIPE_MASK = 5'b00100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [SWR-1:0] data_i,
  input  logic           dir_i,
  input  logic [EWR-1:0] shamt_i,
  input  logic           fill_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [SWR-1:0] data_o
`ifdef BSP_STICKY_EN
  ,
  output logic           sticky_o
`endif
);

  function automatic int popcount(input logic [EWR-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < EWR; i++) n += int'(m[i]);
    return n;
  endfunction

  localparam int LAT = popcount(PIPE_MASK);

  // Handshake: an input transfers on a rising edge when valid_i && ready_o; an
  // output transfers when valid_o && ready_i. All stages move together whenever
  // the last stage is empty or being drained, so ready_o is that global advance.
  logic advance;

  // Stage boundary k feeds level k; boundary EWR is the output.
  logic [SWR-1:0] st_data  [EWR+1];
  logic [EWR-1:0] st_shamt [EWR+1];
  logic           st_dir   [EWR+1];
  logic           st_fill  [EWR+1];
  logic           st_valid [EWR+1];
`ifdef BSP_STICKY_EN
  logic           st_sticky[EWR+1];
`endif

  assign st_data[0]  = data_i;
  assign st_shamt[0] = shamt_i;
  assign st_dir[0]   = dir_i;
  assign st_fill[0]  = fill_i;
  assign st_valid[0] = valid_i;
`ifdef BSP_STICKY_EN
  assign st_sticky[0] = 1'b0;
`endif

  generate
    for (genvar k = 0; k < EWR; k++) begin : g_lvl
      localparam int SH  = 1 << k;
      localparam int SHC = (SH < SWR) ? SH : SWR;
      localparam logic [EWR-1:0] LOW_MASK = EWR'((1 << k) - 1);

      logic [SWR-1:0] shifted;
      logic [SWR-1:0] lvl_data;

      if (SH < SWR) begin : g_part
        assign shifted = st_dir[k] ? {st_data[k][SWR-1-SH:0], {SH{st_fill[k]}}}
                                   : {{SH{st_fill[k]}}, st_data[k][SWR-1:SH]};
      end else begin : g_full
        assign shifted = {SWR{st_fill[k]}};
      end

      assign lvl_data = st_shamt[k][k] ? shifted : st_data[k];

`ifdef BSP_STICKY_EN
      logic lvl_disc;
      logic lvl_sticky;

      // Earlier levels have already shifted by the low shamt bits; positions
      // occupied by fill bits from those levels must not feed the sticky.
      always_comb begin
        int cum;
        cum      = int'(st_shamt[k] & LOW_MASK);
        lvl_disc = 1'b0;
        for (int j = 0; j < SHC; j++) begin
          if (st_dir[k]) begin
            if ((SWR - 1 - j) >= cum) lvl_disc = lvl_disc | st_data[k][SWR-1-j];
          end else begin
            if (j < (SWR - cum)) lvl_disc = lvl_disc | st_data[k][j];
          end
        end
      end

      assign lvl_sticky = st_sticky[k] | (st_shamt[k][k] & lvl_disc);
`endif

      if (PIPE_MASK[k]) begin : g_reg
        logic [SWR-1:0] r_data;
        logic [EWR-1:0] r_shamt;
        logic           r_dir;
        logic           r_fill;
        logic           r_valid;
`ifdef BSP_STICKY_EN
        logic           r_sticky;
`endif

        always_ff @(posedge clk) begin
          if (rst) begin
            r_data   <= '0;
            r_shamt  <= '0;
            r_dir    <= 1'b0;
            r_fill   <= 1'b0;
            r_valid  <= 1'b0;
`ifdef BSP_STICKY_EN
            r_sticky <= 1'b0;
`endif
          end else if (flush_i) begin
            r_valid  <= 1'b0;
          end else if (advance) begin
            r_data   <= lvl_data;
            r_shamt  <= st_shamt[k];
            r_dir    <= st_dir[k];
            r_fill   <= st_fill[k];
            r_valid  <= st_valid[k];
`ifdef BSP_STICKY_EN
            r_sticky <= lvl_sticky;
`endif
          end
        end

        assign st_data[k+1]   = r_data;
        assign st_shamt[k+1]  = r_shamt;
        assign st_dir[k+1]    = r_dir;
        assign st_fill[k+1]   = r_fill;
        assign st_valid[k+1]  = r_valid;
`ifdef BSP_STICKY_EN
        assign st_sticky[k+1] = r_sticky;
`endif
      end else begin : g_comb
        assign st_data[k+1]   = lvl_data;
        assign st_shamt[k+1]  = st_shamt[k];
        assign st_dir[k+1]    = st_dir[k];
        assign st_fill[k+1]   = st_fill[k];
        assign st_valid[k+1]  = st_valid[k];
`ifdef BSP_STICKY_EN
        assign st_sticky[k+1] = lvl_sticky;
`endif
      end
    end
  endgenerate

  assign valid_o = st_valid[EWR];
  assign data_o  = st_data[EWR];
`ifdef BSP_STICKY_EN
  assign sticky_o = st_sticky[EWR];
`endif

  // With no registers the block is a pure wire path, so readiness is downstream's.
  assign advance = (LAT == 0) ? ready_i : (!valid_o || ready_i);
  assign ready_o = advance;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: three instances (L=1, L=5, L=0)
// driven from shared inputs and checked against a behavioural shift model.
module tb_barrel_shift_pipe;
  localparam int SWR = 26;
  localparam int EWR = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, flush_i, valid_i, dir_i, fill_i, ready_i;
  logic [SWR-1:0] data_i;
  logic [EWR-1:0] shamt_i;

  logic a_ready, a_valid, b_ready, b_valid, c_ready, c_valid;
  logic [SWR-1:0] a_data, b_data, c_data;
`ifdef BSP_STICKY_EN
  logic a_sticky, b_sticky, c_sticky;
`endif

  barrel_shift_pipe #(.SWR(SWR), .EWR(EWR), .PIPE_MASK(5'b00100)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(a_ready),
    .data_i(data_i), .dir_i(dir_i), .shamt_i(shamt_i), .fill_i(fill_i),
    .valid_o(a_valid), .ready_i(ready_i), .data_o(a_data)
`ifdef BSP_STICKY_EN
    , .sticky_o(a_sticky)
`endif
  );

  barrel_shift_pipe #(.SWR(SWR), .EWR(EWR), .PIPE_MASK(5'b11111)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(b_ready),
    .data_i(data_i), .dir_i(dir_i), .shamt_i(shamt_i), .fill_i(fill_i),
    .valid_o(b_valid), .ready_i(ready_i), .data_o(b_data)
`ifdef BSP_STICKY_EN
    , .sticky_o(b_sticky)
`endif
  );

  barrel_shift_pipe #(.SWR(SWR), .EWR(EWR), .PIPE_MASK(5'b00000)) dut_c (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(c_ready),
    .data_i(data_i), .dir_i(dir_i), .shamt_i(shamt_i), .fill_i(fill_i),
    .valid_o(c_valid), .ready_i(ready_i), .data_o(c_data)
`ifdef BSP_STICKY_EN
    , .sticky_o(c_sticky)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int sel          = 0;
  int lat          = 1;
  bit strict       = 1'b0;

  logic [SWR:0] exp_q[$];
  int           acc_q[$];

  logic           o_valid, o_ready, o_sticky;
  logic [SWR-1:0] o_data;

  always_comb begin
    o_valid  = (sel == 1) ? b_valid : a_valid;
    o_ready  = (sel == 1) ? b_ready : a_ready;
    o_data   = (sel == 1) ? b_data  : a_data;
    o_sticky = 1'b0;
`ifdef BSP_STICKY_EN
    o_sticky = (sel == 1) ? b_sticky : a_sticky;
`endif
  end

  // Reference: whole shift computed at once from the amount, {sticky, data}.
  function automatic logic [SWR:0] ref_word(input logic [SWR-1:0] d, input logic dir,
                                            input logic [EWR-1:0] sh, input logic f);
    logic [SWR-1:0] ones, r;
    logic s;
    ones = '1;
    if (int'(sh) >= SWR) begin
      r = {SWR{f}};
      s = |d;
    end else if (dir) begin
      r = (d << sh) | (f ? ~(ones << sh) : '0);
      s = |(d & ~(ones >> sh));
    end else begin
      r = (d >> sh) | (f ? ~(ones >> sh) : '0);
      s = |(d & ~(ones << sh));
    end
    return {s, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [SWR-1:0] d, input logic dr,
                        input logic [EWR-1:0] sh, input logic f, input logic rdy);
    valid_i = v; data_i = d; dir_i = dr; shamt_i = sh; fill_i = f; ready_i = rdy;
  endtask

  // Inputs are already applied at a falling edge; score, then move to the next one.
  task automatic cycle();
    logic acc, expv;
    #1;
    acc = valid_i && o_ready && !flush_i && !rst;
    if (rst || flush_i) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (acc) begin
        exp_q.push_back(ref_word(data_i, dir_i, shamt_i, fill_i));
        acc_q.push_back(cyc);
      end
      if (strict) begin
        expv = (exp_q.size() > 0) && (acc_q[0] == cyc - lat);
        chk("valid_o timing", {31'd0, o_valid}, {31'd0, expv});
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious valid_o", {31'd0, o_valid}, 32'd0);
        end else begin
          chk("data_o", {6'd0, o_data}, {6'd0, exp_q[0][SWR-1:0]});
`ifdef BSP_STICKY_EN
          chk("sticky_o", {31'd0, o_sticky}, {31'd0, exp_q[0][SWR]});
`endif
          if (ready_i) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [SWR-1:0] d, input logic dr,
                       input logic [EWR-1:0] sh, input logic f, input logic rdy);
    set_in(v, d, dr, sh, f, rdy);
    cycle();
  endtask

  task automatic rand_op(input logic v, input logic rdy);
    drive(v, SWR'($urandom), 1'($urandom_range(0, 1)), EWR'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush_i = 1'b0;
    set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [SWR:0] w;
    rst = 1'b0; flush_i = 1'b0;
    set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);

    // ---- L=1 (default mask) ----
    sel = 0; lat = 1; strict = 1'b1;
    do_reset();
    chk("reset valid_a", {31'd0, a_valid}, 32'd0);
    chk("reset data_a", {6'd0, a_data}, 32'd0);
    chk("reset valid_b", {31'd0, b_valid}, 32'd0);
    chk("reset data_b", {6'd0, b_data}, 32'd0);
`ifdef BSP_STICKY_EN
    chk("reset sticky_a", {31'd0, a_sticky}, 32'd0);
`endif
    drive(1'b1, 26'h3FFFFFF, 1'b0, 5'd4,  1'b0, 1'b1);
    drive(1'b1, 26'h0000001, 1'b1, 5'd3,  1'b1, 1'b1);
    drive(1'b1, 26'h1234567, 1'b0, 5'd31, 1'b0, 1'b1);
    drive(1'b1, 26'h2AAAAAA, 1'b1, 5'd0,  1'b1, 1'b1);
    drive(1'b1, 26'h2AAAAAA, 1'b0, 5'd25, 1'b1, 1'b1);
    drive(1'b1, 26'h2AAAAAA, 1'b1, 5'd26, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("drain directed", exp_q.size(), 32'd0);

    strict = 1'b0;
    for (int i = 0; i < 30; i++) rand_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("drain random L1", exp_q.size(), 32'd0);

    // Backpressure: values 1,2,3 with shamt 0, downstream stalls after first output.
    drive(1'b1, 26'd1, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 26'd2, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("stall ready_o", {31'd0, a_ready}, 32'd0);
      chk("stall valid_o", {31'd0, a_valid}, 32'd1);
      chk("stall data_o", {6'd0, a_data}, 32'd1);
      cycle();
    end
    drive(1'b1, 26'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b1, 26'd3, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("drain backpressure", exp_q.size(), 32'd0);

    // ---- L=5 (all levels registered) ----
    sel = 1; lat = 5; strict = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) rand_op(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("drain back-to-back", exp_q.size(), 32'd0);

    strict = 1'b0;
    for (int i = 0; i < 40; i++) rand_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 12; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("drain random L5", exp_q.size(), 32'd0);

    // Flush with three operations in flight; the input in the flush cycle is dropped.
    strict = 1'b1;
    for (int i = 0; i < 3; i++) rand_op(1'b1, 1'b1);
    flush_i = 1'b1;
    rand_op(1'b1, 1'b1);
    flush_i = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) rand_op(1'b1, 1'b1);
    rst = 1'b1;
    rand_op(1'b1, 1'b1);
    rst = 1'b0;
    set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("mid reset valid_o", {31'd0, b_valid}, 32'd0);
    chk("mid reset data_o", {6'd0, b_data}, 32'd0);
    for (int i = 0; i < 6; i++) cycle();

    // ---- L=0 (combinational) ----
    for (int i = 0; i < 24; i++) begin
      set_in(1'($urandom_range(0, 1)), SWR'($urandom), 1'($urandom_range(0, 1)),
             EWR'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      w = ref_word(data_i, dir_i, shamt_i, fill_i);
      chk("comb valid_o", {31'd0, c_valid}, {31'd0, valid_i});
      chk("comb ready_o", {31'd0, c_ready}, {31'd0, ready_i});
      chk("comb data_o", {6'd0, c_data}, {6'd0, w[SWR-1:0]});
`ifdef BSP_STICKY_EN
      chk("comb sticky_o", {31'd0, c_sticky}, {31'd0, w[SWR]});
`endif
      @(negedge clk);
      cyc++;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
